pallete_position_ctrl: RTL and testbench
========================================

Name: pallete_position_ctrl

Overview:
- Hardware paddle mover that turns raw push buttons into the 11-bit pallete_position bus consumed by vga_example.
- Directly upstream of the VGA stage; it replaces the GPIO-driven software path to the paddle position.
- Runs in the 65 MHz pixel clock domain.
- Synchronises and debounces the buttons, then moves the paddle once per frame with speed ramp-up and clamping at the screen edges.

Parameters:
- POS_MIN, 0, lowest legal paddle position (pixels).
- POS_MAX, 896, highest legal paddle position (1024 - 128 paddle width).
- POS_INIT, 448, position loaded at reset.
- DEBOUNCE_CYCLES, 650000, stable cycles required before a button change is accepted (10 ms at 65 MHz).
- SPEED_MIN, 2, pixels per frame on the first moving frame.
- SPEED_MAX, 16, saturation speed (pixels per frame).
- ACCEL_FRAMES, 8, held frames between speed increments.

Ports:
- clk  input  1  pixel clock, 65 MHz.
- reset_n  input  1  synchronous, active-low reset.
- button  input  2  raw asynchronous buttons: [0] = left/decrease, [1] = right/increase.
- vs_in  input  1  vertical sync from the VGA timing stage; active-low pulse.
- pallete_position  output  11  paddle position to vga_example.
- moving  output  1  high while the FSM is in MOVE_DEC or MOVE_INC.
- speed  output  5  current speed, for LED debug.

Behaviour:
- Reset: reset_n sampled on the clk rising edge only; no asynchronous path.
- Values while and after reset_n=0:
  - pallete_position = POS_INIT.
  - moving = 0.
  - speed = 0.
  - FSM = IDLE.
  - Synchronisers, debounce counters, held-frame counter and vs edge register all cleared; the debounced button state is 0.
- Reset asserted mid-move takes effect on the next edge; no partial step is applied.
- Synchroniser: 2-flop synchroniser per button bit and on vs_in.
- Debounce, per bit, independent:
  - The counter clears whenever the synced input equals the debounced state.
  - Otherwise it increments.
  - On reaching DEBOUNCE_CYCLES-1 the debounced state toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never propagates.
- Frame tick: a one-cycle pulse on the synced vs falling edge, i.e. the start of the sync pulse. Exactly one tick per frame.
- FSM, evaluated only on a tick cycle; outputs hold between ticks:
  - IDLE: db=01 -> MOVE_DEC; db=10 -> MOVE_INC; db=00 or 11 -> stay.
  - On entering a MOVE state: speed = SPEED_MIN, held-frame counter = 0, and the first step is applied on that same tick.
  - In a MOVE state:
    - Direction button released, or both buttons pressed -> IDLE, speed = 0, no step.
    - Opposite button only -> the other MOVE state, speed restarts at SPEED_MIN, and the step in the new direction is applied on that tick.
    - Otherwise stay; held counter +1. When it reaches ACCEL_FRAMES-1 it wraps to 0 and speed = min(speed+1, SPEED_MAX).
- Step arithmetic:
  - 12-bit signed intermediate.
  - MOVE_DEC: pos - speed; if the result < POS_MIN, load POS_MIN.
  - MOVE_INC: pos + speed; if the result > POS_MAX, load POS_MAX.
  - No wrap-around ever.
  - At a limit the FSM stays in its MOVE state and moving stays 1, but the position is unchanged.
- Latency:
  - pallete_position is registered and changes on the clock edge after the tick cycle.
  - It is constant for the rest of the frame, so the VGA stage never sees a change mid-frame apart from during sync.
- Button change versus frame tick in the same cycle: the FSM uses the debounced state registered before that edge, so the change takes effect on the next tick.
- moving = (state != IDLE). speed reports the speed applied on the last tick, or 0 in IDLE.

Test Plan:
Simulation runs with DEBOUNCE_CYCLES=4, ACCEL_FRAMES=2, and vs_in pulsed every 100 cycles.
- Reset: hold reset_n=0 for 5 cycles while button=10 -> pallete_position=448, moving=0, speed=0 throughout; no move on the first tick after release until the debounce completes.
- Bounce: toggle button[1] every 2 cycles for 20 cycles, then hold 0 -> debounced state never changes; position stays 448 over 3 frames.
- Ramp: hold button=10 for 10 frames -> position after each tick is 450, 452, 455, 458, 462, 466, 471, 476, 482, 488; speed ends at 6.
- Clamp high: start at 890 with speed 16, button=10 -> position becomes 896 and stays 896 on later ticks; moving=1.
- Clamp low: hold button=01 from 448 until saturated -> position reaches 0 and never underflows (no 2047 value).
- Both/reversal: holding 10 then pressing 11 -> IDLE, no step. Going from 10 straight to 01 -> the next tick steps -2 (speed restarts at 2).

Source files
------------

// File: rtl/pallete_position_ctrl.sv
// Button-driven paddle mover: synchronises and debounces two buttons, then steps the
// paddle once per frame on the vsync falling edge, with speed ramp-up and edge clamping.
module pallete_position_ctrl #(
  parameter int POS_MIN         = 0,
  parameter int POS_MAX         = 896,
  parameter int POS_INIT        = 448,
  parameter int DEBOUNCE_CYCLES = 650000,
  parameter int SPEED_MIN       = 2,
  parameter int SPEED_MAX       = 16,
  parameter int ACCEL_FRAMES    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  button,
  input  logic        vs_in,
  output logic [10:0] pallete_position,
  output logic        moving,
  output logic [4:0]  speed
);

  // state    | meaning
  // IDLE     | paddle parked, speed reported as 0
  // MOVE_DEC | left held alone, stepping towards POS_MIN
  // MOVE_INC | right held alone, stepping towards POS_MAX
  typedef enum logic [1:0] {IDLE, MOVE_DEC, MOVE_INC} state_t;

  localparam int DBW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int HW  = $clog2(ACCEL_FRAMES) + 1;

  localparam logic [DBW-1:0]   DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0]    HELD_LAST = HW'(ACCEL_FRAMES - 1);
  localparam logic [4:0]       SPD_MIN   = 5'(SPEED_MIN);
  localparam logic [4:0]       SPD_MAX   = 5'(SPEED_MAX);
  localparam logic signed [11:0] LIM_LO  = 12'(POS_MIN);
  localparam logic signed [11:0] LIM_HI  = 12'(POS_MAX);
  localparam logic [10:0]      INIT_POS  = 11'(POS_INIT);

  logic [1:0] btn_meta, btn_sync, db;
  logic       vs_meta, vs_sync, vs_prev;
  logic       tick;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      btn_meta <= '0;
      btn_sync <= '0;
      vs_meta  <= 1'b0;
      vs_sync  <= 1'b0;
      vs_prev  <= 1'b0;
    end else begin
      btn_meta <= button;
      btn_sync <= btn_meta;
      vs_meta  <= vs_in;
      vs_sync  <= vs_meta;
      vs_prev  <= vs_sync;
    end
  end

  // Start of the active-low sync pulse marks the frame boundary.
  assign tick = vs_prev & ~vs_sync;

  for (genvar i = 0; i < 2; i++) begin : g_db
    logic [DBW-1:0] cnt;
    logic           state_q;

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt     <= '0;
        state_q <= 1'b0;
      end else if (btn_sync[i] == state_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt     <= '0;
        state_q <= ~state_q;
      end else begin
        cnt <= cnt + DBW'(1);
      end
    end

    assign db[i] = state_q;
  end

  state_t      state;
  logic [HW-1:0] held, held_nxt;
  logic [4:0]  spd_up;
  logic        go_dec, go_inc;

  assign go_dec = (db == 2'b01);
  assign go_inc = (db == 2'b10);

  always_comb begin
    held_nxt = held + HW'(1);
    spd_up   = speed;
    if (held == HELD_LAST) begin
      held_nxt = '0;
      spd_up   = (speed < SPD_MAX) ? speed + 5'd1 : SPD_MAX;
    end
  end

  function automatic logic [10:0] step(input logic [10:0] p, input logic [4:0] s,
                                       input logic inc);
    logic signed [11:0] r;
    if (inc) begin
      r = $signed({1'b0, p}) + $signed({7'b0, s});
      if (r > LIM_HI) r = LIM_HI;
    end else begin
      r = $signed({1'b0, p}) - $signed({7'b0, s});
      if (r < LIM_LO) r = LIM_LO;
    end
    return r[10:0];
  endfunction

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= IDLE;
      pallete_position <= INIT_POS;
      moving           <= 1'b0;
      speed            <= 5'd0;
      held             <= '0;
    end else if (tick) begin
      if (!go_dec && !go_inc) begin
        state  <= IDLE;
        moving <= 1'b0;
        speed  <= 5'd0;
      end else if ((go_dec && state != MOVE_DEC) || (go_inc && state != MOVE_INC)) begin
        // Entry from IDLE and direction reversal both restart the ramp and step at once.
        state            <= go_inc ? MOVE_INC : MOVE_DEC;
        moving           <= 1'b1;
        speed            <= SPD_MIN;
        held             <= '0;
        pallete_position <= step(pallete_position, SPD_MIN, go_inc);
      end else begin
        held             <= held_nxt;
        speed            <= spd_up;
        pallete_position <= step(pallete_position, spd_up, go_inc);
      end
    end
  end

endmodule

// File: tb/tb_pallete_position_ctrl.sv
// Bench for pallete_position_ctrl: reset/bounce/ramp/clamp/reversal sequences and
// random per-frame buttons, checked against a frame-level reference model.
`timescale 1ns/1ps
module tb_pallete_position_ctrl;

  localparam int PMIN = 0;
  localparam int PMAX = 896;
  localparam int PINIT = 448;
  localparam int SMIN = 2;
  localparam int SMAX = 16;
  localparam int AF = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  button;
  logic        vs_in;
  logic [10:0] pallete_position;
  logic        moving;
  logic [4:0]  speed;

  int n_checks = 0;
  int n_err = 0;

  int m_pos, m_speed, m_held, m_dir;

  typedef struct {
    logic [1:0] b;
    int         pos;
    int         mov;
    int         spd;
  } vec_t;

  vec_t tbl[16];

  pallete_position_ctrl #(
    .POS_MIN(PMIN), .POS_MAX(PMAX), .POS_INIT(PINIT), .DEBOUNCE_CYCLES(4),
    .SPEED_MIN(SMIN), .SPEED_MAX(SMAX), .ACCEL_FRAMES(AF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .button(button),
    .vs_in(vs_in),
    .pallete_position(pallete_position),
    .moving(moving),
    .speed(speed)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pos = PINIT; m_speed = 0; m_held = 0; m_dir = 0;
  endtask

  // One frame tick as seen with debounced buttons b.
  task automatic model_tick(input logic [1:0] b);
    int want;
    want = (b == 2'b01) ? -1 : (b == 2'b10) ? 1 : 0;
    if (want == 0) begin
      m_dir = 0; m_speed = 0;
      return;
    end
    if (want != m_dir) begin
      m_dir = want; m_speed = SMIN; m_held = 0;
    end else if (m_held == AF - 1) begin
      m_held = 0;
      if (m_speed < SMAX) m_speed++;
    end else begin
      m_held++;
    end
    m_pos = m_pos + want * m_speed;
    if (m_pos < PMIN) m_pos = PMIN;
    if (m_pos > PMAX) m_pos = PMAX;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pos"}, int'(pallete_position), m_pos);
    check({tag, "_moving"}, int'(moving), (m_dir != 0) ? 1 : 0);
    check({tag, "_speed"}, int'(speed), m_speed);
  endtask

  // 100-cycle frame: buttons held from frame start, vsync low for 5 cycles near the end.
  task automatic run_frame(input logic [1:0] b, input string tag);
    button = b;
    repeat (45) @(negedge clk);
    check({tag, "_midframe_pos"}, int'(pallete_position), m_pos);
    repeat (45) @(negedge clk);
    vs_in = 1'b0;
    model_tick(b);
    repeat (5) @(negedge clk);
    vs_in = 1'b1;
    repeat (5) @(negedge clk);
    check_model(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{2'b10, 450, 1, 2};
    tbl[1]  = '{2'b10, 452, 1, 2};
    tbl[2]  = '{2'b10, 455, 1, 3};
    tbl[3]  = '{2'b10, 458, 1, 3};
    tbl[4]  = '{2'b10, 462, 1, 4};
    tbl[5]  = '{2'b10, 466, 1, 4};
    tbl[6]  = '{2'b10, 471, 1, 5};
    tbl[7]  = '{2'b10, 476, 1, 5};
    tbl[8]  = '{2'b10, 482, 1, 6};
    tbl[9]  = '{2'b10, 488, 1, 6};
    tbl[10] = '{2'b01, 486, 1, 2};
    tbl[11] = '{2'b01, 484, 1, 2};
    tbl[12] = '{2'b11, 484, 0, 0};
    tbl[13] = '{2'b10, 486, 1, 2};
    tbl[14] = '{2'b11, 486, 0, 0};
    tbl[15] = '{2'b00, 486, 0, 0};

    // Reset with right button held: outputs pinned at reset values.
    reset_n = 1'b0;
    button  = 2'b10;
    vs_in   = 1'b1;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("reset_pos", int'(pallete_position), PINIT);
      check("reset_moving", int'(moving), 0);
      check("reset_speed", int'(speed), 0);
    end
    reset_n = 1'b1;

    // Tick arrives before the button has finished debouncing: no move.
    @(negedge clk);
    vs_in = 1'b0;
    repeat (6) @(negedge clk);
    model_tick(2'b00);
    vs_in = 1'b1;
    check("early_tick_pos", int'(pallete_position), PINIT);
    check("early_tick_moving", int'(moving), 0);
    repeat (10) @(negedge clk);
    run_frame(2'b00, "release");

    // Bounce on button[1] spanning a tick never reaches the debounced state.
    repeat (50) @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      button[1] = ~button[1];
      if (i == 5) vs_in = 1'b0;
      repeat (2) @(negedge clk);
    end
    button = 2'b00;
    vs_in  = 1'b1;
    model_tick(2'b00);
    repeat (10) @(negedge clk);
    check("bounce_pos", int'(pallete_position), PINIT);
    check("bounce_moving", int'(moving), 0);
    for (int i = 0; i < 3; i++) begin
      run_frame(2'b00, "bounce_hold");
      check("bounce_hold_448", int'(pallete_position), PINIT);
    end

    // Ramp, reversal, both-pressed table.
    for (int i = 0; i < 16; i++) begin
      run_frame(tbl[i].b, "table");
      check($sformatf("tbl%0d_pos", i), int'(pallete_position), tbl[i].pos);
      check($sformatf("tbl%0d_moving", i), int'(moving), tbl[i].mov);
      check($sformatf("tbl%0d_speed", i), int'(speed), tbl[i].spd);
    end

    // Clamp at the right edge.
    for (int i = 0; i < 60; i++) begin
      run_frame(2'b10, "clamp_hi");
      check("clamp_hi_bound", (int'(pallete_position) <= PMAX) ? 1 : 0, 1);
    end
    check("clamp_hi_final_pos", int'(pallete_position), PMAX);
    check("clamp_hi_moving", int'(moving), 1);
    check("clamp_hi_speed", int'(speed), SMAX);

    // Clamp at the left edge, never underflowing.
    for (int i = 0; i < 80; i++) begin
      run_frame(2'b01, "clamp_lo");
      check("clamp_lo_no_wrap", (int'(pallete_position) <= PMAX) ? 1 : 0, 1);
    end
    check("clamp_lo_final_pos", int'(pallete_position), PMIN);
    check("clamp_lo_moving", int'(moving), 1);
    check("clamp_lo_speed", int'(speed), SMAX);

    // Random buttons, one pattern per frame, held for a few frames at a time.
    for (int i = 0; i < 60; i++) begin
      logic [1:0] b;
      int reps;
      b = 2'($urandom_range(0, 3));
      reps = $urandom_range(1, 4);
      for (int k = 0; k < reps; k++) run_frame(b, "random");
    end

    // Reset in the middle of a move.
    run_frame(2'b10, "pre_reset");
    run_frame(2'b10, "pre_reset");
    repeat (20) @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midmove_reset_pos", int'(pallete_position), PINIT);
    check("midmove_reset_moving", int'(moving), 0);
    check("midmove_reset_speed", int'(speed), 0);
    reset_n = 1'b1;
    model_reset();
    run_frame(2'b10, "post_reset");
    check("post_reset_pos", int'(pallete_position), PINIT + SMIN);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
